dma_mem_arbiter: RTL and testbench

- Shares the single 32-bit Avalon-MM memory slave port (burstcount 1, byteenable 4'b1111) between two word-access requesters.
- Port 0 is the HPS disk DMA path. Port 1 is a secondary loader/debug requester.
- Each requester issues single-cycle rd/wr pulses and sees a busy flag, the same semantics as ioctl_wait.
- The block latches commands, arbitrates round-robin, sequences the Avalon handshake, returns read data and times out lost reads.

---
 rtl/dma_mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dma_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_arbiter.sv
// dma_mem_arbiter
//   Shares one 32-bit Avalon-MM memory slave port (burstcount 1, all byte
//   lanes enabled) between two word-access requesters. Port 0 is the HPS disk
//   DMA path and port 1 is a secondary loader/debug requester.
//
//   Each requester sends a single-cycle rd or wr pulse and then watches its
//   busy flag, the same handshake as ioctl_wait. The block latches the
//   command, arbitrates round-robin, runs the Avalon handshake, returns the
//   read data and aborts reads that never see readdatavalid.
//
// Ports
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   reqN_rd / reqN_wr           command pulses (rd wins if both are high)
//   reqN_addr / reqN_wdata      byte address and write data, sampled with the pulse
//   reqN_rdata                  read data, valid when busy falls after a read
//   reqN_busy                   command in progress; pulses are dropped while high
//   avm_*                       Avalon-MM master side, one transaction at a time
//   err / err_clr               sticky read-timeout flag and its clear
module dma_mem_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic [31:0] req0_rdata,
  output logic        req0_busy,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic [31:0] req1_rdata,
  output logic        req1_busy,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_pend, w_pend_nxt;
  logic [1:0]       r_busy, w_busy_nxt;
  logic [1:0]       r_op_rd;
  logic [1:0][31:0] r_addr, r_wdata;
  logic [1:0][31:0] r_rdata, w_rdata_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic             r_gnt, w_gnt_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             r_avm_read, w_avm_read_nxt;
  logic             r_avm_write, w_avm_write_nxt;
  logic [31:0]      r_avm_address, w_avm_address_nxt;
  logic [31:0]      r_avm_writedata, w_avm_writedata_nxt;

  logic [1:0]       w_cap;
  logic             w_gnt_any;
  logic             w_gnt_sel;
  logic             w_timeout_hit;

  // A pulse is only accepted while its port is idle; anything else is dropped.
  assign w_cap[0] = (req0_rd | req0_wr) & ~r_busy[0];
  assign w_cap[1] = (req1_rd | req1_wr) & ~r_busy[1];

  // Both pending: take the port that did not win last time. One pending: take it.
  assign w_gnt_any     = |r_pend;
  assign w_gnt_sel     = (&r_pend) ? ~r_last_grant : r_pend[1];
  assign w_timeout_hit = (r_cnt == CNT_LAST);

  // Command latches
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_rd <= '0;
    end else begin
      if (w_cap[0]) begin
        r_addr[0]  <= req0_addr;
        r_wdata[0] <= req0_wdata;
        r_op_rd[0] <= req0_rd;
      end
      if (w_cap[1]) begin
        r_addr[1]  <= req1_addr;
        r_wdata[1] <= req1_wdata;
        r_op_rd[1] <= req1_rd;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_pend          <= '0;
      r_busy          <= '0;
      r_rdata         <= '0;
      r_last_grant    <= 1'b1;
      r_gnt           <= 1'b0;
      r_cnt           <= '0;
      r_err           <= 1'b0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pend          <= w_pend_nxt;
      r_busy          <= w_busy_nxt;
      r_rdata         <= w_rdata_nxt;
      r_last_grant    <= w_last_grant_nxt;
      r_gnt           <= w_gnt_nxt;
      r_cnt           <= w_cnt_nxt;
      r_err           <= w_err_nxt;
      r_avm_read      <= w_avm_read_nxt;
      r_avm_write     <= w_avm_write_nxt;
      r_avm_address   <= w_avm_address_nxt;
      r_avm_writedata <= w_avm_writedata_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_pend_nxt          = r_pend | w_cap;
    w_busy_nxt          = r_busy | w_cap;
    w_rdata_nxt         = r_rdata;
    w_last_grant_nxt    = r_last_grant;
    w_gnt_nxt           = r_gnt;
    w_cnt_nxt           = r_cnt;
    w_err_nxt           = r_err & ~err_clr;
    w_avm_read_nxt      = r_avm_read;
    w_avm_write_nxt     = r_avm_write;
    w_avm_address_nxt   = r_avm_address;
    w_avm_writedata_nxt = r_avm_writedata;

    case (r_state)
      S_IDLE: begin
        // Pending is a registered flag, so a fresh capture waits one edge.
        if (w_gnt_any) begin
          w_gnt_nxt             = w_gnt_sel;
          w_last_grant_nxt      = w_gnt_sel;
          w_pend_nxt[w_gnt_sel] = 1'b0;
          w_avm_address_nxt     = r_addr[w_gnt_sel];
          w_avm_writedata_nxt   = r_wdata[w_gnt_sel];
          w_avm_read_nxt        = r_op_rd[w_gnt_sel];
          w_avm_write_nxt       = ~r_op_rd[w_gnt_sel];
          w_state_nxt           = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!avm_waitrequest) begin
          w_avm_read_nxt  = 1'b0;
          w_avm_write_nxt = 1'b0;
          if (r_avm_read) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_RD;
          end else begin
            w_busy_nxt[r_gnt] = 1'b0;
            w_state_nxt       = S_IDLE;
          end
        end
      end

      S_WAIT_RD: begin
        w_cnt_nxt = r_cnt + 16'd1;
        // Valid beats the timeout when both land on the same edge.
        if (avm_readdatavalid) begin
          w_rdata_nxt[r_gnt] = avm_readdata;
          w_busy_nxt[r_gnt]  = 1'b0;
          w_state_nxt        = S_IDLE;
        end else if (w_timeout_hit) begin
          w_rdata_nxt[r_gnt] = 32'hFFFF_FFFF;
          w_busy_nxt[r_gnt]  = 1'b0;
          w_err_nxt          = 1'b1;
          w_state_nxt        = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req0_rdata    = r_rdata[0];
  assign req1_rdata    = r_rdata[1];
  assign req0_busy     = r_busy[0];
  assign req1_busy     = r_busy[1];
  assign avm_address   = r_avm_address;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_writedata;
  assign err           = r_err;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
module tb_dma_mem_arbiter;

  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [31:0] req0_rdata, req1_rdata;
  logic        req0_busy, req1_busy;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic        err, err_clr;

  always #5 clk_sys = ~clk_sys;

  dma_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .req0_rd          (req0_rd),
    .req0_wr          (req0_wr),
    .req0_addr        (req0_addr),
    .req0_wdata       (req0_wdata),
    .req0_rdata       (req0_rdata),
    .req0_busy        (req0_busy),
    .req1_rd          (req1_rd),
    .req1_wr          (req1_wr),
    .req1_addr        (req1_addr),
    .req1_wdata       (req1_wdata),
    .req1_rdata       (req1_rdata),
    .req1_busy        (req1_busy),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .err              (err),
    .err_clr          (err_clr)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_wr_acc = 0;
  int   n_rd_acc = 0;

  // Avalon scoreboard: every accepted transaction must match the next expected one.
  always @(negedge clk_sys) begin
    if (reset_n && (avm_read || avm_write) && !avm_waitrequest) begin
      if (avm_read) n_rd_acc++;
      else n_wr_acc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL avm_unexpected: read=%0b write=%0b addr=%h, expected no transaction",
                 avm_read, avm_write, avm_address);
      end else begin
        mon_e = exp_q.pop_front();
        if (avm_read !== mon_e.rd || avm_write !== !mon_e.rd || avm_address !== mon_e.addr ||
            (!mon_e.rd && avm_writedata !== mon_e.data)) begin
          errors++;
          $display("FAIL avm_txn: got rd=%0b wr=%0b addr=%h data=%h, expected rd=%0b addr=%h data=%h",
                   avm_read, avm_write, avm_address, avm_writedata, mon_e.rd, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin errors++;
      $display("FAIL reset_rdwr: got %0b%0b, expected 00", avm_read, avm_write); end
    checks++; if (avm_address !== 32'h0 || avm_writedata !== 32'h0) begin errors++;
      $display("FAIL reset_addr_data: got %h %h, expected 0 0", avm_address, avm_writedata); end
    checks++; if (req0_busy !== 1'b0 || req1_busy !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_busy_err: got %0b %0b %0b, expected 0 0 0", req0_busy, req1_busy, err); end
    checks++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h %h, expected 0 0", req0_rdata, req1_rdata); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int k0, k1, cyc, wacc;
    localparam int N = 4;
    // Saturated traffic from reset: port 0 first, then strict alternation.
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({1'b0, 32'h0000_A000 + 32'(k * 4), 32'hA000_0000 + 32'(k)});
      exp_q.push_back({1'b0, 32'h0000_B000 + 32'(k * 4), 32'hB000_0000 + 32'(k)});
    end
    wacc = n_wr_acc;
    k0 = 0; k1 = 0; cyc = 0;
    while ((k0 < N || k1 < N || req0_busy || req1_busy) && cyc < 400) begin
      if (!req0_busy && k0 < N) begin
        req0_wr = 1'b1; req0_addr = 32'h0000_A000 + 32'(k0 * 4); req0_wdata = 32'hA000_0000 + 32'(k0); k0++;
      end else req0_wr = 1'b0;
      if (!req1_busy && k1 < N) begin
        req1_wr = 1'b1; req1_addr = 32'h0000_B000 + 32'(k1 * 4); req1_wdata = 32'hB000_0000 + 32'(k1); k1++;
      end else req1_wr = 1'b0;
      avm_waitrequest = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    req0_wr = 1'b0; req1_wr = 1'b0; avm_waitrequest = 1'b0;
    tick();
    checks++; if (cyc >= 400) begin errors++;
      $display("FAIL fair_timeout: got %0d cycles, expected < 400", cyc); end
    checks++; if (n_wr_acc !== wacc + 2 * N || exp_q.size() != 0) begin errors++;
      $display("FAIL fair_count: got %0d writes (%0d left), expected %0d (0 left)",
               n_wr_acc - wacc, exp_q.size(), 2 * N); end
    // Port 0 wins alone, so the next simultaneous pair must go to port 1 first.
    exp_q.push_back({1'b0, 32'h0000_C000, 32'hC0C0_0000});
    exp_q.push_back({1'b0, 32'h0000_D004, 32'hD0D0_0001});
    exp_q.push_back({1'b0, 32'h0000_C004, 32'hC0C0_0001});
    req0_wr = 1'b1; req0_addr = 32'h0000_C000; req0_wdata = 32'hC0C0_0000;
    tick(); req0_wr = 1'b0;
    tick(); tick();
    req0_wr = 1'b1; req0_addr = 32'h0000_C004; req0_wdata = 32'hC0C0_0001;
    req1_wr = 1'b1; req1_addr = 32'h0000_D004; req1_wdata = 32'hD0D0_0001;
    tick(); req0_wr = 1'b0; req1_wr = 1'b0;
    repeat (5) tick();
    checks++; if (exp_q.size() != 0 || req0_busy !== 1'b0 || req1_busy !== 1'b0) begin errors++;
      $display("FAIL fair_last_grant: got %0d left busy=%0b%0b, expected 0 left busy=00",
               exp_q.size(), req0_busy, req1_busy); end
  endtask

  task automatic test_single_write();
    int wacc;
    wacc = n_wr_acc;
    exp_q.push_back({1'b0, 32'h0000_1000, 32'hDEAD_BEEF});
    req0_wr = 1'b1; req0_addr = 32'h0000_1000; req0_wdata = 32'hDEAD_BEEF;
    tick(); req0_wr = 1'b0;
    checks++; if (req0_busy !== 1'b1 || avm_write !== 1'b0) begin errors++;
      $display("FAIL wr_edge0: got busy=%0b write=%0b, expected 1 0", req0_busy, avm_write); end
    tick();
    checks++; if (avm_write !== 1'b1 || avm_address !== 32'h0000_1000 || avm_writedata !== 32'hDEAD_BEEF || req0_busy !== 1'b1) begin errors++;
      $display("FAIL wr_edge1: got write=%0b addr=%h data=%h busy=%0b, expected 1 00001000 deadbeef 1",
               avm_write, avm_address, avm_writedata, req0_busy); end
    tick();
    checks++; if (avm_write !== 1'b0 || req0_busy !== 1'b0) begin errors++;
      $display("FAIL wr_edge2: got write=%0b busy=%0b, expected 0 0", avm_write, req0_busy); end
    tick();
    checks++; if (n_wr_acc !== wacc + 1) begin errors++;
      $display("FAIL wr_count: got %0d, expected 1", n_wr_acc - wacc); end
  endtask

  task automatic test_read_wait();
    exp_q.push_back({1'b1, 32'h0000_0010, 32'h0});
    avm_waitrequest = 1'b1;
    req1_rd = 1'b1; req1_addr = 32'h0000_0010;
    tick(); req1_rd = 1'b0;
    checks++; if (req1_busy !== 1'b1) begin errors++;
      $display("FAIL rd_busy_set: got %0b, expected 1", req1_busy); end
    tick();
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h10) begin errors++;
      $display("FAIL rd_issue: got read=%0b addr=%h, expected 1 00000010", avm_read, avm_address); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (avm_read !== 1'b1 || avm_address !== 32'h10) begin errors++;
        $display("FAIL rd_hold%0d: got read=%0b addr=%h, expected 1 00000010", i, avm_read, avm_address); end
    end
    avm_waitrequest = 1'b0;
    tick();
    checks++; if (avm_read !== 1'b0 || req1_busy !== 1'b1) begin errors++;
      $display("FAIL rd_accept: got read=%0b busy=%0b, expected 0 1", avm_read, req1_busy); end
    tick();
    checks++; if (req1_busy !== 1'b1) begin errors++;
      $display("FAIL rd_wait: got busy=%0b, expected 1", req1_busy); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
    tick(); avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    checks++; if (req1_busy !== 1'b0 || req1_rdata !== 32'h1234_5678) begin errors++;
      $display("FAIL rd_done: got busy=%0b rdata=%h, expected 0 12345678", req1_busy, req1_rdata); end
  endtask

  task automatic test_timeout();
    exp_q.push_back({1'b1, 32'h0000_0020, 32'h0});
    req0_rd = 1'b1; req0_addr = 32'h0000_0020;
    tick(); req0_rd = 1'b0;
    tick(); tick();
    repeat (TO - 1) tick();
    checks++; if (req0_busy !== 1'b1 || err !== 1'b0) begin errors++;
      $display("FAIL to_early: got busy=%0b err=%0b, expected 1 0", req0_busy, err); end
    tick();
    checks++; if (req0_busy !== 1'b0 || req0_rdata !== 32'hFFFF_FFFF || err !== 1'b1) begin errors++;
      $display("FAIL to_abort: got busy=%0b rdata=%h err=%0b, expected 0 ffffffff 1", req0_busy, req0_rdata, err); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_5555;
    tick(); avm_readdatavalid = 1'b0;
    tick();
    checks++; if (req0_rdata !== 32'hFFFF_FFFF || req1_rdata !== 32'h1234_5678 || err !== 1'b1) begin errors++;
      $display("FAIL to_late_valid: got %h %h err=%0b, expected ffffffff 12345678 1", req0_rdata, req1_rdata, err); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL to_err_clr: got %0b, expected 0", err); end
    // Valid on the very edge the timeout would fire.
    exp_q.push_back({1'b1, 32'h0000_0030, 32'h0});
    req1_rd = 1'b1; req1_addr = 32'h0000_0030;
    tick(); req1_rd = 1'b0;
    tick(); tick();
    repeat (TO - 1) tick();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A5_0003;
    tick(); avm_readdatavalid = 1'b0;
    checks++; if (req1_busy !== 1'b0 || req1_rdata !== 32'hA5A5_0003 || err !== 1'b0) begin errors++;
      $display("FAIL to_coincide: got busy=%0b rdata=%h err=%0b, expected 0 a5a50003 0", req1_busy, req1_rdata, err); end
  endtask

  task automatic test_busy_drop();
    int wacc;
    wacc = n_wr_acc;
    exp_q.push_back({1'b0, 32'h0000_0040, 32'h1111_1111});
    avm_waitrequest = 1'b1;
    req0_wr = 1'b1; req0_addr = 32'h0000_0040; req0_wdata = 32'h1111_1111;
    tick();
    req0_addr = 32'h0000_0044; req0_wdata = 32'h2222_2222;
    tick(); req0_wr = 1'b0;
    checks++; if (avm_write !== 1'b1 || avm_address !== 32'h40 || avm_writedata !== 32'h1111_1111) begin errors++;
      $display("FAIL drop_hold: got write=%0b addr=%h data=%h, expected 1 00000040 11111111", avm_write, avm_address, avm_writedata); end
    tick(); avm_waitrequest = 1'b0;
    repeat (4) tick();
    checks++; if (n_wr_acc !== wacc + 1 || req0_busy !== 1'b0) begin errors++;
      $display("FAIL drop_count: got %0d writes busy=%0b, expected 1 0", n_wr_acc - wacc, req0_busy); end
    exp_q.push_back({1'b1, 32'h0000_0048, 32'h0});
    req0_rd = 1'b1; req0_wr = 1'b1; req0_addr = 32'h0000_0048;
    tick(); req0_rd = 1'b0; req0_wr = 1'b0;
    tick();
    checks++; if (avm_read !== 1'b1 || avm_write !== 1'b0) begin errors++;
      $display("FAIL rdwr_op: got read=%0b write=%0b, expected 1 0", avm_read, avm_write); end
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_0001;
    tick(); avm_readdatavalid = 1'b0;
    checks++; if (req0_busy !== 1'b0 || req0_rdata !== 32'hCAFE_0001) begin errors++;
      $display("FAIL rdwr_done: got busy=%0b rdata=%h, expected 0 cafe0001", req0_busy, req0_rdata); end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({1'b1, 32'h0000_0050, 32'h0});
    req1_rd = 1'b1; req1_addr = 32'h0000_0050;
    tick(); req1_rd = 1'b0;
    tick(); tick(); tick();
    #2; reset_n = 1'b0;
    #1;
    checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 32'h0 || avm_writedata !== 32'h0) begin errors++;
      $display("FAIL mid_reset_avm: got %0b%0b %h %h, expected 00 0 0", avm_read, avm_write, avm_address, avm_writedata); end
    checks++; if (req0_busy !== 1'b0 || req1_busy !== 1'b0 || req0_rdata !== 32'h0 || req1_rdata !== 32'h0 || err !== 1'b0) begin errors++;
      $display("FAIL mid_reset_req: got %0b %0b %h %h %0b, expected 0 0 0 0 0", req0_busy, req1_busy, req0_rdata, req1_rdata, err); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 32'h0000_0060, 32'h6060_6060});
    req1_wr = 1'b1; req1_addr = 32'h0000_0060; req1_wdata = 32'h6060_6060;
    tick(); req1_wr = 1'b0;
    tick();
    checks++; if (avm_write !== 1'b1 || avm_address !== 32'h60) begin errors++;
      $display("FAIL post_reset_wr: got write=%0b addr=%h, expected 1 00000060", avm_write, avm_address); end
    tick();
    checks++; if (req1_busy !== 1'b0 || exp_q.size() != 0) begin errors++;
      $display("FAIL post_reset_done: got busy=%0b left=%0d, expected 0 0", req1_busy, exp_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    req0_rd = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_rd = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_fairness();
    test_single_write();
    test_read_wait();
    test_timeout();
    test_busy_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
